// File: rtl/discrete_dac_playback.sv
// discrete_dac_playback: FIFO-buffered code playback to an R2R ladder bus and a PWM pin.
// Codes are primed to half-full, then popped one per sample slot; the PWM duty reloads only at period wrap.
module discrete_dac_playback #(
    parameter int WIDTH       = 8,
    parameter int CLOCK_FREQ  = 100_000_000,
    parameter int SAMPLE_FREQ = 48_000,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH-1:0]              s_data,
    output logic [WIDTH-1:0]              r2r_out,
    output logic                          pwm_out,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = CLOCK_FREQ / SAMPLE_FREQ;
    localparam int TW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d, duty_q, duty_d, r2r_q, r2r_d;
    logic             pwm_q, pwm_d, tick_q, tick_d, under_q, under_d;
    logic             run, play, slot, push, pop;

    always_ff @(posedge clk)
        state_q <= !reset ? IDLE : state_d;

    always_comb
        state_d = !enable ? IDLE :
                  state_q == IDLE ? PRIME :
                  (state_q == PRIME && level_q >= LW'(FIFO_DEPTH / 2)) ? PLAY : state_q;

    // run: FIFO live (not flushing); play: timers and outputs active
    always_comb begin
        run  = enable && state_q != IDLE;
        play = enable && state_q == PLAY;
        slot = play && timer_q == TW'(DIV - 1);
    end

    assign s_ready = level_q != LW'(FIFO_DEPTH);
    assign push    = run && s_valid && s_ready;
    assign pop     = slot && level_q != '0;

    always_comb begin
        level_d = !run ? '0 : level_q + LW'(push) - LW'(pop);
        wr_d    = !run ? '0 : wr_q + AW'(push);
        rd_d    = !run ? '0 : rd_q + AW'(pop);
        timer_d = !play ? '0 : slot ? '0 : timer_q + 1'b1;
        r2r_d   = !play ? '0 : pop ? mem[rd_q] : r2r_q;
        tick_d  = slot;
        under_d = slot && level_q == '0;
        pcnt_d  = !play ? '0 : pcnt_q + 1'b1;
        duty_d  = !play ? '0 : &pcnt_q ? r2r_q : duty_q;
        pwm_d   = play && pcnt_q < duty_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            timer_q <= '0;
            r2r_q   <= '0;
            tick_q  <= 1'b0;
            under_q <= 1'b0;
            pcnt_q  <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            timer_q <= timer_d;
            r2r_q   <= r2r_d;
            tick_q  <= tick_d;
            under_q <= under_d;
            pcnt_q  <= pcnt_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    always_ff @(posedge clk)
        if (reset && push) mem[wr_q] <= s_data;

    assign r2r_out     = r2r_q;
    assign pwm_out     = pwm_q;
    assign sample_tick = tick_q;
    assign underrun    = under_q;
    assign fifo_level  = level_q;
endmodule

// File: tb/tb_discrete_dac_playback.sv
// tb_discrete_dac_playback: queue-based reference model checked every cycle, plus directed corner sequences.
module tb_discrete_dac_playback;
    localparam int W   = 8;
    localparam int D   = 16;
    localparam int CF  = 30_000_000;
    localparam int SF  = 100_000;
    localparam int DIV = CF / SF;
    localparam int LW  = $clog2(D) + 1;

    logic          clk = 1'b0, reset = 1'b0, enable = 1'b0, s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready, pwm_out, sample_tick, underrun;
    logic [W-1:0]  r2r_out;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    discrete_dac_playback #(.WIDTH(W), .CLOCK_FREQ(CF), .SAMPLE_FREQ(SF), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .r2r_out(r2r_out), .pwm_out(pwm_out), .sample_tick(sample_tick),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    int checks = 0, errors = 0;

    // reference model: mode 0=idle, 1=prime, 2=play; FIFO as a queue
    int           m_mode = 0, m_timer = 0, m_pcnt = 0, m_duty = 0;
    logic [W-1:0] m_r2r = '0;
    bit           m_tick = 0, m_under = 0, m_pwm = 0;
    logic [W-1:0] m_q[$];

    typedef struct { logic [W-1:0] code; int high; } pwm_vec_t;
    pwm_vec_t tv[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        int sz = m_q.size();
        bit slot, psh, pp;
        if (!reset || !enable) begin
            m_mode = 0; m_timer = 0; m_pcnt = 0; m_duty = 0; m_r2r = '0;
            m_tick = 0; m_under = 0; m_pwm = 0; m_q.delete();
            return;
        end
        psh = m_mode != 0 && s_valid && sz < D;
        slot = m_mode == 2 && m_timer == DIV - 1;
        pp = slot && sz > 0;
        m_tick = slot;
        m_under = slot && sz == 0;
        m_pwm = m_mode == 2 && m_pcnt < m_duty;
        if (m_mode == 2) begin
            if (m_pcnt == 2**W - 1) m_duty = m_r2r;
            m_pcnt = (m_pcnt + 1) % (2**W);
            m_timer = slot ? 0 : m_timer + 1;
        end
        if (pp) m_r2r = m_q.pop_front();
        if (psh) m_q.push_back(s_data);
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && sz >= D / 2) m_mode = 2;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("s_ready", s_ready, m_q.size() != D);
        chk("fifo_level", fifo_level, m_q.size());
        chk("r2r_out", r2r_out, m_r2r);
        chk("sample_tick", sample_tick, m_tick);
        chk("underrun", underrun, m_under);
        chk("pwm_out", pwm_out, m_pwm);
    endtask

    task automatic push(input logic [W-1:0] d);
        s_valid = 1'b1;
        s_data = d;
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin step(); n++; end while (!sample_tick && n < 4 * DIV);
        if (!sample_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic flush();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
    endtask

    initial begin
        int n, hi;
        tv[0] = '{8'h00, 0};
        tv[1] = '{8'h80, 128};
        tv[2] = '{8'hFF, 255};
        tv[3] = '{8'h01, 1};
        tv[4] = '{8'h40, 64};

        // reset held for 3 cycles
        reset = 1'b0;
        repeat (3) step();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_r2r", r2r_out, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_level", fifo_level, 0);
        reset = 1'b1;

        // prime 0x10..0x17, first slot DIV cycles after PLAY entry
        enable = 1'b1;
        step();
        for (int i = 0; i < 8; i++) push(W'(8'h10 + i));
        chk("primed_level", fifo_level, 8);
        wait_tick(n);
        chk("first_slot_latency", n, DIV + 1);
        chk("first_code", r2r_out, 8'h10);
        for (int k = 1; k < 4; k++) begin
            wait_tick(n);
            chk("slot_period", n, DIV);
            chk("next_code", r2r_out, 8'h10 + k);
        end

        // full FIFO back-pressure and release after a pop
        flush();
        chk("flush_level", fifo_level, 0);
        s_valid = 1'b1;
        for (int i = 0; i < D; i++) begin s_data = W'(i); step(); end
        chk("full_level", fifo_level, D);
        chk("full_ready", s_ready, 0);
        s_data = 8'hAA;
        step();
        chk("extra_refused", fifo_level, D);
        wait_tick(n);
        chk("pop_level", fifo_level, D - 1);
        chk("ready_after_pop", s_ready, 1);
        step();
        chk("held_accepted", fifo_level, D);
        s_valid = 1'b0;

        // drain to underrun, then push exactly on an empty slot edge
        flush();
        for (int i = 0; i < 8; i++) push(W'(8'h20 + i));
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            chk("drain_code", r2r_out, 8'h20 + k);
            chk("drain_no_underrun", underrun, 0);
        end
        wait_tick(n);
        chk("underrun_pulse", underrun, 1);
        chk("underrun_hold", r2r_out, 8'h27);
        step();
        chk("underrun_one_cycle", underrun, 0);
        repeat (DIV - 2) step();
        push(8'h55);
        chk("push_on_empty_slot_tick", sample_tick, 1);
        chk("push_on_empty_slot_underrun", underrun, 1);
        chk("push_on_empty_slot_level", fifo_level, 1);
        wait_tick(n);
        chk("resume_period", n, DIV);
        chk("resume_code", r2r_out, 8'h55);
        chk("resume_no_underrun", underrun, 0);

        // PWM duty table
        for (int t = 0; t < 5; t++) begin
            flush();
            for (int i = 0; i < 8; i++) push(tv[t].code);
            wait_tick(n);
            repeat (260) step();
            hi = 0;
            for (int c = 0; c < 2**W; c++) begin step(); hi += int'(pwm_out); end
            chk("pwm_high", hi, tv[t].high);
        end

        // enable drop mid-PLAY with level 5, re-enable restarts in PRIME
        flush();
        for (int i = 0; i < 8; i++) push(W'(8'h30 + i));
        repeat (3) wait_tick(n);
        chk("pre_drop_level", fifo_level, 5);
        enable = 1'b0;
        step();
        chk("drop_level", fifo_level, 0);
        chk("drop_r2r", r2r_out, 0);
        chk("drop_pwm", pwm_out, 0);
        enable = 1'b1;
        step();
        push(8'h77);
        chk("reenable_prime_accepts", fifo_level, 1);
        for (int i = 0; i < 7; i++) push(W'(8'h78 + i));
        wait_tick(n);
        chk("reenable_first_code", r2r_out, 8'h77);

        // reset pulse mid-PLAY
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_level", fifo_level, 0);
        chk("midrst_r2r", r2r_out, 0);
        chk("midrst_ready", s_ready, 1);
        chk("midrst_pwm", pwm_out, 0);

        // randomized traffic against the model
        for (int seg = 0; seg < 10; seg++) begin
            int p = (seg % 3 == 0) ? 8 : (seg % 3 == 1) ? 60 : 400;
            for (int c = 0; c < 1500; c++) begin
                s_valid = $urandom_range(p - 1) == 0;
                s_data  = W'($urandom);
                enable  = $urandom_range(2999) != 0;
                reset   = $urandom_range(4999) != 0;
                step();
            end
        end
        reset = 1'b1;
        enable = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
